sine_voice_scheduler: RTL and testbench

Time-multiplexes one shared quarter-wave sine lookup (7-bit angle, 2-bit quadrant, 8-bit offset-binary sample, one-cycle registered latency) across `VOICES` phase accumulators. On each sample tick the block walks all voices in order, advances each gated voice's phase, and issues one table lookup per cycle. It accumulates the returned samples into a signed mix and presents one mixed sample per frame to the downstream audio path.

---
 rtl/vitasound_dds_pkg.sv | 14 +
 rtl/dds_voice_regs.sv | 48 ++++
 rtl/sine_voice_scheduler.sv | 109 ++++++++++
 tb/tb_sine_voice_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vitasound_dds_pkg.sv
// Shared types and helpers for the time-multiplexed DDS voice scheduler.
package vitasound_dds_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} dds_state_e;

    localparam int PHASE_W = 32;
    localparam int SMP_MID = 128;

    // Right-aligns the quadrant and angle fields; callers keep the low n+2 bits.
    function automatic logic [PHASE_W-1:0] phase_field(input logic [PHASE_W-1:0] ph, input int n);
        return ph >> (PHASE_W - 2 - n);
    endfunction

endpackage

// File: rtl/dds_voice_regs.sv
// Per-voice phase/increment/gate storage with a config write port and an issue port.
module dds_voice_regs
    import vitasound_dds_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int VW     = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               wr_en,
    input  logic [VW-1:0]      wr_voice,
    input  logic [PHASE_W-1:0] wr_inc,
    input  logic               wr_gate,
    input  logic               iss_en,
    input  logic [VW-1:0]      iss_voice,
    output logic [PHASE_W-1:0] iss_phase,
    output logic               iss_gate
);

    logic [VOICES-1:0][PHASE_W-1:0] phase;
    logic [VOICES-1:0][PHASE_W-1:0] inc;
    logic [VOICES-1:0]              gate;

    assign iss_phase = phase[iss_voice];
    assign iss_gate  = gate[iss_voice];

    // The issue reads the pre-write inc/gate; a 0->1 gate write can only
    // coincide with a non-advancing issue, so the clear never races an add.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase <= '0;
            inc   <= '0;
            gate  <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (iss_en && iss_voice == VW'(v) && gate[v])
                    phase[v] <= phase[v] + inc[v];
                if (wr_en && wr_voice == VW'(v)) begin
                    inc[v]  <= wr_inc;
                    gate[v] <= wr_gate;
                    if (wr_gate && !gate[v])
                        phase[v] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Walks all voices once per sample tick through one shared sine lookup and
// sums the returned samples into a signed per-frame mix.
module sine_voice_scheduler
    import vitasound_dds_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int N      = 7,
    parameter int SMP_W  = 8,
    parameter int VW     = $clog2(VOICES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SAMPLE_TICK,
    input  logic                cfg_we,
    input  logic [VW-1:0]       cfg_voice,
    input  logic [31:0]         cfg_inc,
    input  logic                cfg_gate,
    output logic [1:0]          tab_quadrant,
    output logic [N-1:0]        tab_angle,
    output logic                tab_req,
    input  logic [SMP_W-1:0]    tab_data,
    output logic [SMP_W+VW-1:0] mix_out,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int AW  = SMP_W + VW;
    localparam int MID = 1 << (SMP_W - 1);

    dds_state_e            state;
    logic [VW-1:0]         vidx;
    logic signed [AW-1:0]  acc;
    logic [1:0]            vld_pipe;
    logic                  start, iss_en, iss_gate;
    logic [VW-1:0]         iss_voice;
    logic [PHASE_W-1:0]    iss_phase;
    logic signed [AW-1:0]  smp_s, contrib;

    assign start     = SAMPLE_TICK && (state == IDLE || state == DONE);
    assign iss_en    = start || (state == ISSUE && vidx != VW'(VOICES - 1));
    assign iss_voice = start ? '0 : vidx + 1'b1;

    dds_voice_regs #(.VOICES(VOICES), .VW(VW)) u_regs (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en     (cfg_we),
        .wr_voice  (cfg_voice),
        .wr_inc    (cfg_inc),
        .wr_gate   (cfg_gate),
        .iss_en    (iss_en),
        .iss_voice (iss_voice),
        .iss_phase (iss_phase),
        .iss_gate  (iss_gate)
    );

    // vld_pipe[1] marks a table result in this cycle from a voice gated at issue.
    assign smp_s   = AW'($signed({1'b0, tab_data})) - AW'(MID);
    assign contrib = vld_pipe[1] ? smp_s : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            vidx         <= '0;
            acc          <= '0;
            vld_pipe     <= '0;
            tab_req      <= 1'b0;
            tab_quadrant <= '0;
            tab_angle    <= '0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            tab_req   <= iss_en;
            vld_pipe  <= {vld_pipe[0], iss_en & iss_gate};
            if (iss_en)
                {tab_quadrant, tab_angle} <= (N + 2)'(phase_field(iss_phase, N));
            mix_valid <= 1'b0;
            overrun   <= SAMPLE_TICK && !(state == IDLE || state == DONE);
            acc       <= acc + contrib;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state <= ISSUE;
                        vidx  <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (vidx == VW'(VOICES - 1))
                        state <= DRAIN;
                    else
                        vidx <= vidx + 1'b1;
                end
                DRAIN: begin
                    mix_out   <= acc + contrib;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Randomized self-checking bench for sine_voice_scheduler with a behavioural voice/mix model.
module tb_sine_voice_scheduler;
    import vitasound_dds_pkg::*;

    localparam int V  = 8;
    localparam int AW = 11;

    logic          CLK = 0, RESET = 0, SAMPLE_TICK = 0;
    logic          cfg_we = 0, cfg_gate = 0;
    logic [2:0]    cfg_voice = '0;
    logic [31:0]   cfg_inc = '0;
    logic [1:0]    tab_quadrant;
    logic [6:0]    tab_angle;
    logic          tab_req;
    logic [7:0]    tab_data = '0;
    logic [AW-1:0] mix_out;
    logic          mix_valid, busy, overrun;

    sine_voice_scheduler dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc), .cfg_gate(cfg_gate),
        .tab_quadrant(tab_quadrant), .tab_angle(tab_angle), .tab_req(tab_req),
        .tab_data(tab_data), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0, n_total = 0;
    int tbl_mode = 0;

    function automatic logic [7:0] tval(input logic [1:0] q, input logic [6:0] a);
        if (tbl_mode == 1) return 8'hFF;
        if (tbl_mode == 2) return 8'h00;
        return {q, a[6:1]} ^ 8'h5A;
    endfunction

    // Stand-in lookup table: one-cycle registered result.
    always @(posedge CLK) if (tab_req) tab_data <= tval(tab_quadrant, tab_angle);

    logic [31:0] m_phase [V];
    logic [31:0] m_inc   [V];
    bit          m_gate  [V];

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin m_phase[v] = 0; m_inc[v] = 0; m_gate[v] = 0; end
    endtask

    task automatic model_cfg(input int v, input logic [31:0] inc, input bit g);
        if (g && !m_gate[v]) m_phase[v] = 0;
        m_inc[v] = inc;
        m_gate[v] = g;
    endtask

    task automatic model_frame(output logic [7:0][8:0] eqa, output int emix);
        emix = 0;
        for (int v = 0; v < V; v++) begin
            int q = int'(m_phase[v] / 32'h4000_0000);
            int a = int'((m_phase[v] / 32'h0080_0000) % 128);
            eqa[v] = {2'(q), 7'(a)};
            if (m_gate[v]) begin
                emix += int'(tval(2'(q), 7'(a))) - SMP_MID;
                m_phase[v] = m_phase[v] + m_inc[v];
            end
        end
    endtask

    task automatic cfg(input int v, input logic [31:0] inc, input bit g);
        cfg_we = 1; cfg_voice = 3'(v); cfg_inc = inc; cfg_gate = g;
        @(negedge CLK);
        cfg_we = 0;
        model_cfg(v, inc, g);
    endtask

    int hk_tick = -1, hk_rst = -1, hk_cfg = -1, hk_snap = -1, hk_len = 14;
    int hk_voice; logic [31:0] hk_inc; bit hk_gate;
    logic [15:0][8:0] o_qa;
    logic [31:0]      o_busy;
    logic [AW-1:0]    o_mix, o_mix2;
    logic [23:0]      o_snap;
    int o_nreq, o_nvalid, o_vcyc, o_vcyc2, o_novr, o_ovr_cyc, o_first, o_last;

    // Tick in cycle 0, then observe cycles 1..hk_len at the falling edge.
    task automatic run_frame();
        o_nreq = 0; o_qa = '0; o_nvalid = 0; o_vcyc = -1; o_vcyc2 = -1; o_mix = '0; o_mix2 = '0;
        o_novr = 0; o_ovr_cyc = -1; o_first = -1; o_last = -1; o_busy = '0; o_snap = '1;
        SAMPLE_TICK = 1;
        for (int k = 1; k <= hk_len; k++) begin
            @(negedge CLK);
            SAMPLE_TICK = (k == hk_tick);
            RESET = (k == hk_rst);
            cfg_we = (k == hk_cfg);
            if (k == hk_cfg) begin cfg_voice = 3'(hk_voice); cfg_inc = hk_inc; cfg_gate = hk_gate; end
            if (tab_req) begin
                if (o_nreq < 16) o_qa[o_nreq] = {tab_quadrant, tab_angle};
                o_nreq++;
                if (o_first < 0) o_first = k;
                o_last = k;
            end
            if (mix_valid) begin
                o_nvalid++;
                if (o_vcyc < 0) begin o_vcyc = k; o_mix = mix_out; end
                else begin o_vcyc2 = k; o_mix2 = mix_out; end
            end
            if (overrun) begin o_novr++; o_ovr_cyc = k; end
            o_busy[k] = busy;
            if (k == hk_snap) o_snap = {tab_req, tab_quadrant, tab_angle, mix_out, mix_valid, busy, overrun};
        end
        SAMPLE_TICK = 0; RESET = 0; cfg_we = 0;
        hk_tick = -1; hk_rst = -1; hk_cfg = -1; hk_snap = -1; hk_len = 14;
    endtask

    logic [7:0][8:0] eqa, eqa2;
    int emix, emix2;

    task automatic test_reset();
        RESET = 1;
        repeat (3) @(negedge CLK);
        n_total++;
        if ({tab_req, tab_quadrant, tab_angle, mix_out, mix_valid, busy, overrun} !== 24'h0)
            $display("FAIL reset_outputs got %h want 0", {tab_req, tab_quadrant, tab_angle, mix_out, mix_valid, busy, overrun});
        else n_pass++;
        RESET = 0;
        model_reset();
        @(negedge CLK);
        n_total++;
        if ({tab_req, mix_valid, busy, overrun} !== 4'b0)
            $display("FAIL reset_release got %b want 0000", {tab_req, mix_valid, busy, overrun});
        else n_pass++;
    endtask

    task automatic test_all_off();
        model_frame(eqa, emix);
        run_frame();
        n_total++;
        if (o_nreq !== 8 || o_first !== 1 || o_last !== 8)
            $display("FAIL alloff_req got n=%0d first=%0d last=%0d want 8/1/8", o_nreq, o_first, o_last);
        else n_pass++;
        n_total++;
        if (o_nvalid !== 1 || o_vcyc !== 10 || o_mix !== AW'(emix))
            $display("FAIL alloff_mix got n=%0d cyc=%0d mix=%0d want 1/10/0", o_nvalid, o_vcyc, o_mix);
        else n_pass++;
        n_total++;
        if (o_busy[1] !== 1'b1 || o_busy[9] !== 1'b1 || o_busy[11] !== 1'b0 || o_busy[0] !== 1'b0)
            $display("FAIL alloff_busy got %b want busy over cycles 1..9", o_busy[14:0]);
        else n_pass++;
    endtask

    task automatic test_quadrants();
        tbl_mode = 0;
        cfg(0, 32'h4000_0000, 1);
        for (int f = 0; f < 5; f++) begin
            model_frame(eqa, emix);
            run_frame();
            n_total++;
            if (o_qa[0] !== {2'(f % 4), 7'd0} || o_qa[7:0] !== eqa || o_mix !== AW'(emix))
                $display("FAIL quad_frame%0d got qa0=%h mix=%0d want qa0=%h mix=%0d", f, o_qa[0], o_mix, {2'(f % 4), 7'd0}, AW'(emix));
            else n_pass++;
        end
    endtask

    task automatic test_rails();
        for (int v = 0; v < V; v++) cfg(v, $urandom, 1);
        tbl_mode = 1;
        run_frame();
        n_total++;
        if (o_mix !== AW'(1016)) $display("FAIL rail_max got %0d want 1016", $signed(o_mix));
        else n_pass++;
        tbl_mode = 2;
        run_frame();
        n_total++;
        if (o_mix !== AW'(-1024)) $display("FAIL rail_min got %0d want -1024", $signed(o_mix));
        else n_pass++;
        model_frame(eqa, emix);
        model_frame(eqa, emix);
        tbl_mode = 0;
    endtask

    task automatic test_overrun();
        model_frame(eqa, emix);
        hk_tick = 3;
        run_frame();
        n_total++;
        if (o_novr !== 1 || o_ovr_cyc !== 4)
            $display("FAIL overrun_pulse got n=%0d cyc=%0d want 1/4", o_novr, o_ovr_cyc);
        else n_pass++;
        n_total++;
        if (o_nvalid !== 1 || o_vcyc !== 10 || o_nreq !== 8 || o_mix !== AW'(emix))
            $display("FAIL overrun_frame got nv=%0d cyc=%0d nreq=%0d mix=%0d want 1/10/8/%0d", o_nvalid, o_vcyc, o_nreq, o_mix, AW'(emix));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        model_frame(eqa, emix);
        model_frame(eqa2, emix2);
        hk_tick = 10; hk_len = 24;
        run_frame();
        n_total++;
        if (o_nvalid !== 2 || o_vcyc !== 10 || o_vcyc2 !== 20 || o_novr !== 0 || o_nreq !== 16)
            $display("FAIL b2b_timing got nv=%0d c1=%0d c2=%0d ovr=%0d nreq=%0d want 2/10/20/0/16", o_nvalid, o_vcyc, o_vcyc2, o_novr, o_nreq);
        else n_pass++;
        n_total++;
        if (o_qa[7:0] !== eqa || o_qa[15:8] !== eqa2 || o_mix !== AW'(emix) || o_mix2 !== AW'(emix2))
            $display("FAIL b2b_data got mix=%0d,%0d want %0d,%0d", o_mix, o_mix2, AW'(emix), AW'(emix2));
        else n_pass++;
    endtask

    task automatic test_cfg_collision();
        for (int v = 0; v < V; v++) cfg(v, 0, 0);
        cfg(3, 32'h0100_0000, 1);
        for (int f = 0; f < 3; f++) begin
            model_frame(eqa, emix);
            if (f == 0) begin hk_cfg = 3; hk_voice = 3; hk_inc = 32'h1000_0000; hk_gate = 1; end
            run_frame();
            if (f == 0) model_cfg(3, 32'h1000_0000, 1);
            n_total++;
            if (o_qa[7:0] !== eqa || o_mix !== AW'(emix))
                $display("FAIL collide_frame%0d got qa3=%h mix=%0d want qa3=%h mix=%0d", f, o_qa[3], o_mix, eqa[3], AW'(emix));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            repeat (2) cfg($urandom_range(V - 1), $urandom, 1'($urandom));
            model_frame(eqa, emix);
            run_frame();
            n_total++;
            if (o_qa[7:0] !== eqa || o_mix !== AW'(emix) || o_vcyc !== 10)
                $display("FAIL random_frame%0d got mix=%0d cyc=%0d qa=%h want mix=%0d cyc=10 qa=%h", f, o_mix, o_vcyc, o_qa[7:0], AW'(emix), eqa);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int v = 0; v < V; v++) cfg(v, $urandom, 1);
        hk_rst = 4; hk_snap = 5;
        run_frame();
        model_reset();
        n_total++;
        if (o_snap !== 24'h0) $display("FAIL rstmid_outputs got %h want 0", o_snap);
        else n_pass++;
        n_total++;
        if (o_nvalid !== 0) $display("FAIL rstmid_novalid got %0d want 0", o_nvalid);
        else n_pass++;
        cfg(1, 32'h2345_6789, 1);
        cfg(6, 32'h8000_0001, 1);
        for (int f = 0; f < 2; f++) begin
            model_frame(eqa, emix);
            run_frame();
            n_total++;
            if (o_qa[7:0] !== eqa || o_mix !== AW'(emix) || o_vcyc !== 10 || o_nvalid !== 1)
                $display("FAIL rstmid_clean%0d got mix=%0d cyc=%0d want mix=%0d cyc=10", f, o_mix, o_vcyc, AW'(emix));
            else n_pass++;
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_all_off();
        test_quadrants();
        test_rails();
        test_overrun();
        test_back_to_back();
        test_cfg_collision();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
